// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared scan constants, state encoding and blanking helper
package freq_meter_pkg;

    localparam int SEG_COUNT   = 7;
    localparam int DIGIT_COUNT = 4;

    localparam logic [2:0] SEG_LAST   = 3'(SEG_COUNT - 1);
    localparam logic [2:0] SEG_OFF    = 3'(SEG_COUNT);
    localparam logic [1:0] DIGIT_LAST = 2'(DIGIT_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } scan_state_t;

    // True when digit idx and every more significant digit are zero; digit 0 always shows.
    function automatic logic lead_zero(input logic [15:0] digits, input logic [1:0] idx);
        logic r;
        case (idx)
            2'd3:    r = (digits[15:12] == 4'd0);
            2'd2:    r = (digits[15:8]  == 8'd0);
            2'd1:    r = (digits[15:4]  == 12'd0);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - BCD to 7-segment pattern, bit 0 = segment a, 1 = lit
module seg7_decode (
    input  logic [3:0] i_Bcd,
    output logic [6:0] o_Seg
);

    always_comb begin
        o_Seg = 7'h00;
        case (i_Bcd)
            4'd0:    o_Seg = 7'h3F;
            4'd1:    o_Seg = 7'h06;
            4'd2:    o_Seg = 7'h5B;
            4'd3:    o_Seg = 7'h4F;
            4'd4:    o_Seg = 7'h66;
            4'd5:    o_Seg = 7'h6D;
            4'd6:    o_Seg = 7'h7D;
            4'd7:    o_Seg = 7'h07;
            4'd8:    o_Seg = 7'h7F;
            4'd9:    o_Seg = 7'h6F;
            default: o_Seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - serial 4-digit 7-segment scan controller with
// double-buffered digits applied on frame boundaries
module disp_scan_ctrl
    import freq_meter_pkg::*;
#(
    parameter int GAP_CYCLES     = 1,
    parameter bit SEG_ACTIVE_LOW = 1
) (
    input  logic       clk_500u,
    input  logic       i_RST,
    input  logic       i_En,
    input  logic       i_Load,
    input  logic [3:0] i_D0,
    input  logic [3:0] i_D1,
    input  logic [3:0] i_D2,
    input  logic [3:0] i_D3,
    input  logic       i_Blank_En,
    output logic [1:0] o_Disp,
    output logic [2:0] o_SegSel,
    output logic       o_SegData,
    output logic       o_Frame,
    output logic       o_Ack
);

    localparam logic [2:0] GAP_LAST = 3'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

    scan_state_t                       r_state;
    logic [1:0]                        r_disp;
    logic [2:0]                        r_segsel;
    logic [2:0]                        r_gap_cnt;
    logic                              r_frame;
    logic                              r_ack;
    logic [DIGIT_COUNT-1:0][3:0]       r_active;
    logic [DIGIT_COUNT-1:0][3:0]       r_shadow;
    logic                              r_pending;
    logic                              r_blank_en;
    logic                              r_run_ok;

    logic       w_digit_done;
    logic       w_wrap;
    logic       w_start;
    logic       w_apply;
    logic [3:0] w_digit;
    logic [6:0] w_seg;
    logic [7:0] w_seg_ext;
    logic       w_blanked;
    logic       w_lit;

    // End of a digit slot: last segment with no gap, or last gap cycle.
    assign w_digit_done = ((r_state == ST_SHIFT) && (r_segsel == SEG_LAST) && (GAP_CYCLES == 0))
                       || ((r_state == ST_GAP) && (r_gap_cnt == GAP_LAST));
    assign w_wrap  = w_digit_done && (r_disp == DIGIT_LAST);
    assign w_start = (r_state == ST_IDLE) && r_run_ok;
    assign w_apply = i_En && r_pending && (w_wrap || w_start);

    assign w_digit = r_active[r_disp];

    seg7_decode u_decode (
        .i_Bcd (w_digit),
        .o_Seg (w_seg)
    );

    assign w_seg_ext = {1'b0, w_seg};
    assign w_blanked = r_blank_en && lead_zero(r_active, r_disp);
    assign w_lit     = (r_state == ST_SHIFT) && !w_blanked && w_seg_ext[r_segsel];

    assign o_Disp    = r_disp;
    assign o_SegSel  = r_segsel;
    assign o_SegData = w_lit ^ SEG_ACTIVE_LOW;
    assign o_Frame   = r_frame;
    assign o_Ack     = r_ack;

    // r_run_ok holds the scan in IDLE for one edge after reset release.
    always_ff @(posedge clk_500u or negedge i_RST) begin
        if (!i_RST) begin
            r_state    <= ST_IDLE;
            r_disp     <= 2'd0;
            r_segsel   <= SEG_OFF;
            r_gap_cnt  <= 3'd0;
            r_frame    <= 1'b0;
            r_ack      <= 1'b0;
            r_active   <= '0;
            r_shadow   <= '0;
            r_pending  <= 1'b0;
            r_blank_en <= 1'b0;
            r_run_ok   <= 1'b0;
        end else begin
            r_run_ok   <= 1'b1;
            r_blank_en <= i_Blank_En;
            r_frame    <= 1'b0;
            r_ack      <= w_apply;

            if (w_apply)
                r_active <= r_shadow;

            // A load on the applying edge leaves the new data pending.
            if (i_Load) begin
                r_shadow  <= {i_D3, i_D2, i_D1, i_D0};
                r_pending <= 1'b1;
            end else if (w_apply) begin
                r_pending <= 1'b0;
            end

            if (!i_En) begin
                r_state   <= ST_IDLE;
                r_disp    <= 2'd0;
                r_segsel  <= SEG_OFF;
                r_gap_cnt <= 3'd0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (r_run_ok) begin
                            r_state  <= ST_SHIFT;
                            r_disp   <= 2'd0;
                            r_segsel <= 3'd0;
                        end
                    end
                    ST_SHIFT: begin
                        if (r_segsel == SEG_LAST) begin
                            if (GAP_CYCLES > 0) begin
                                r_state   <= ST_GAP;
                                r_segsel  <= SEG_OFF;
                                r_gap_cnt <= 3'd0;
                            end else begin
                                r_disp   <= r_disp + 2'd1;
                                r_segsel <= 3'd0;
                                r_frame  <= (r_disp == DIGIT_LAST);
                            end
                        end else begin
                            r_segsel <= r_segsel + 3'd1;
                        end
                    end
                    ST_GAP: begin
                        if (r_gap_cnt == GAP_LAST) begin
                            r_state  <= ST_SHIFT;
                            r_disp   <= r_disp + 2'd1;
                            r_segsel <= 3'd0;
                            r_frame  <= (r_disp == DIGIT_LAST);
                        end else begin
                            r_gap_cnt <= r_gap_cnt + 3'd1;
                        end
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_disp   <= 2'd0;
                        r_segsel <= SEG_OFF;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb/tb_disp_scan_ctrl.sv - scoreboard bench for disp_scan_ctrl at default parameters
module tb_disp_scan_ctrl;

    logic       clk_500u = 1'b0;
    logic       i_RST = 1'b1;
    logic       i_En = 1'b0;
    logic       i_Load = 1'b0;
    logic [3:0] i_D0 = 4'd0, i_D1 = 4'd0, i_D2 = 4'd0, i_D3 = 4'd0;
    logic       i_Blank_En = 1'b0;
    logic [1:0] o_Disp;
    logic [2:0] o_SegSel;
    logic       o_SegData;
    logic       o_Frame;
    logic       o_Ack;

    typedef struct packed {
        logic [1:0] disp;
        logic [2:0] sel;
        logic       data;
        logic       frame;
        logic       ack;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    disp_scan_ctrl dut (
        .clk_500u   (clk_500u),
        .i_RST      (i_RST),
        .i_En       (i_En),
        .i_Load     (i_Load),
        .i_D0       (i_D0),
        .i_D1       (i_D1),
        .i_D2       (i_D2),
        .i_D3       (i_D3),
        .i_Blank_En (i_Blank_En),
        .o_Disp     (o_Disp),
        .o_SegSel   (o_SegSel),
        .o_SegData  (o_SegData),
        .o_Frame    (o_Frame),
        .o_Ack      (o_Ack)
    );

    always #5 clk_500u = ~clk_500u;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b0111111;
            4'd1: return 7'b0000110;
            4'd2: return 7'b1011011;
            4'd3: return 7'b1001111;
            4'd4: return 7'b1100110;
            4'd5: return 7'b1101101;
            4'd6: return 7'b1111101;
            4'd7: return 7'b0000111;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o = {o_Disp, o_SegSel, o_SegData, o_Frame, o_Ack};
        return o;
    endfunction

    function automatic string fmt(input exp_t e);
        return $sformatf("disp=%0d sel=%0d data=%b frame=%b ack=%b", e.disp, e.sel, e.data, e.frame, e.ack);
    endfunction

    task automatic tick();
        @(posedge clk_500u);
        #1;
    endtask

    task automatic set_digits(input logic [15:0] v);
        {i_D3, i_D2, i_D1, i_D0} = v;
    endtask

    task automatic push_idle(input int n);
        exp_t e;
        e = '{disp: 2'd0, sel: 3'd7, data: 1'b1, frame: 1'b0, ack: 1'b0};
        for (int k = 0; k < n; k++) sb.push_back(e);
    endtask

    // Expected 32-cycle frame: 4 digits x (7 segments + 1 gap), active-low segments.
    task automatic push_frame(input logic [15:0] val, input logic blank, input logic frm,
                              input logic ack, input int n = 32);
        exp_t       e;
        logic [6:0] pat;
        logic       off;
        int         k;
        k = 0;
        for (int d = 0; d < 4; d++) begin
            pat = seg_of(val[d*4 +: 4]);
            off = blank && (d > 0) && ((val >> (d * 4)) == 16'd0);
            for (int s = 0; s < 8; s++) begin
                e.disp  = 2'(d);
                e.sel   = 3'(s);
                e.data  = (s == 7 || off) ? 1'b1 : ~pat[s];
                e.frame = (k == 0) && frm;
                e.ack   = (k == 0) && ack;
                if (k < n) sb.push_back(e);
                k++;
            end
        end
    endtask

    task automatic test_reset();
        exp_t e;
        int   i;
        #2 i_RST = 1'b0;
        #2;
        push_idle(1);
        e = sb.pop_front();
        n_cmp++;
        if (observed() !== e) begin
            n_bad++;
            $display("FAIL reset_now: got %s, expected %s", fmt(observed()), fmt(e));
        end
        push_idle(2);
        i = 0;
        while (sb.size() > 0) begin
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (observed() !== e) begin
                n_bad++;
                $display("FAIL reset_hold step %0d: got %s, expected %s", i, fmt(observed()), fmt(e));
            end
            i++;
        end
    endtask

    task automatic test_scan();
        exp_t e;
        int   i;
        i_RST = 1'b1;
        i_En = 1'b1;
        i_Load = 1'b1;
        set_digits(16'h1234);
        push_idle(1);
        push_frame(16'h1234, 1'b0, 1'b0, 1'b1);
        push_frame(16'h1234, 1'b0, 1'b1, 1'b0);
        i = 0;
        while (sb.size() > 0) begin
            if (i == 1) i_Load = 1'b0;
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (observed() !== e) begin
                n_bad++;
                $display("FAIL scan step %0d: got %s, expected %s", i, fmt(observed()), fmt(e));
            end
            i++;
        end
    endtask

    task automatic test_blanking();
        exp_t e;
        int   i;
        push_frame(16'h1234, 1'b0, 1'b1, 1'b0);
        push_frame(16'h0007, 1'b1, 1'b1, 1'b1);
        push_frame(16'h0007, 1'b0, 1'b1, 1'b0);
        i = 0;
        while (sb.size() > 0) begin
            if (i == 0) begin i_Load = 1'b1; set_digits(16'h0007); i_Blank_En = 1'b1; end
            if (i == 1) i_Load = 1'b0;
            if (i == 64) i_Blank_En = 1'b0;
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (observed() !== e) begin
                n_bad++;
                $display("FAIL blanking step %0d: got %s, expected %s", i, fmt(observed()), fmt(e));
            end
            i++;
        end
    endtask

    task automatic test_multi_load();
        exp_t e;
        int   i;
        push_frame(16'h0007, 1'b0, 1'b1, 1'b0);
        push_frame(16'h6666, 1'b0, 1'b1, 1'b1);
        i = 0;
        while (sb.size() > 0) begin
            if (i == 5) begin i_Load = 1'b1; set_digits(16'h5555); end
            if (i == 6) i_Load = 1'b0;
            if (i == 7) begin i_Load = 1'b1; set_digits(16'h6666); end
            if (i == 8) i_Load = 1'b0;
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (observed() !== e) begin
                n_bad++;
                $display("FAIL multi_load step %0d: got %s, expected %s", i, fmt(observed()), fmt(e));
            end
            i++;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   i;
        push_frame(16'h6666, 1'b0, 1'b1, 1'b0);
        push_frame(16'h1111, 1'b0, 1'b1, 1'b1);
        push_frame(16'h2222, 1'b0, 1'b1, 1'b1);
        i = 0;
        while (sb.size() > 0) begin
            if (i == 3) begin i_Load = 1'b1; set_digits(16'h1111); end
            if (i == 4) i_Load = 1'b0;
            if (i == 32) begin i_Load = 1'b1; set_digits(16'h2222); end
            if (i == 33) i_Load = 1'b0;
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (observed() !== e) begin
                n_bad++;
                $display("FAIL back_to_back step %0d: got %s, expected %s", i, fmt(observed()), fmt(e));
            end
            i++;
        end
    endtask

    task automatic test_enable_drop();
        exp_t e;
        int   i;
        push_frame(16'h2222, 1'b0, 1'b1, 1'b0, 20);
        push_idle(5);
        push_frame(16'h3333, 1'b0, 1'b0, 1'b1);
        push_frame(16'h3333, 1'b0, 1'b1, 1'b0);
        i = 0;
        while (sb.size() > 0) begin
            if (i == 20) i_En = 1'b0;
            if (i == 22) begin i_Load = 1'b1; set_digits(16'h3333); end
            if (i == 23) i_Load = 1'b0;
            if (i == 25) i_En = 1'b1;
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (observed() !== e) begin
                n_bad++;
                $display("FAIL enable_drop step %0d: got %s, expected %s", i, fmt(observed()), fmt(e));
            end
            i++;
        end
    endtask

    task automatic test_reset_mid_frame();
        exp_t e;
        int   i;
        push_frame(16'h3333, 1'b0, 1'b1, 1'b0, 30);
        i = 0;
        while (sb.size() > 0) begin
            if (i == 2) begin i_Load = 1'b1; set_digits(16'h4444); end
            if (i == 3) i_Load = 1'b0;
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (observed() !== e) begin
                n_bad++;
                $display("FAIL reset_mid run step %0d: got %s, expected %s", i, fmt(observed()), fmt(e));
            end
            i++;
        end
        i_RST = 1'b0;
        #1;
        push_idle(1);
        e = sb.pop_front();
        n_cmp++;
        if (observed() !== e) begin
            n_bad++;
            $display("FAIL reset_mid async: got %s, expected %s", fmt(observed()), fmt(e));
        end
        push_idle(3);
        push_idle(1);
        push_frame(16'h0000, 1'b0, 1'b0, 1'b0);
        push_frame(16'h0000, 1'b0, 1'b1, 1'b0);
        i = 0;
        while (sb.size() > 0) begin
            if (i == 3) i_RST = 1'b1;
            tick();
            e = sb.pop_front();
            n_cmp++;
            if (observed() !== e) begin
                n_bad++;
                $display("FAIL reset_mid restart step %0d: got %s, expected %s", i, fmt(observed()), fmt(e));
            end
            i++;
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_blanking();
        test_multi_load();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 1, meaning blank cycles inserted after each digit's 7 segments (legal range 0..7).
REQ-002 SHALL have parameter SEG_ACTIVE_LOW, default 1, meaning a lit segment is driven 0 and an unlit segment is driven 1.
REQ-003 clk_500u  input  1  scan clock; all state updates on the rising edge.
REQ-004 i_RST  input  1  reset, asynchronous, active-low.
REQ-005 i_En  input  1  scan enable; low forces IDLE.
REQ-006 i_Load  input  1  single-cycle strobe: capture i_D0..i_D3 as a new measurement.
REQ-007 i_D0, i_D1, i_D2, i_D3  input  4 each  BCD digits; i_D0 is least significant.
REQ-008 i_Blank_En  input  1  enables leading-zero blanking.
REQ-009 o_Disp  output  2  currently addressed digit (0..3).
REQ-010 o_SegSel  output  3  currently addressed segment (0..6); value 7 during GAP and IDLE.
REQ-011 o_SegData  output  1  serial segment value for (o_Disp, o_SegSel).
REQ-012 o_Frame  output  1  one-cycle pulse marking a frame boundary.
REQ-013 o_Ack  output  1  one-cycle pulse when pending data becomes the displayed data.

Function
REQ-014 SHALL implement the states IDLE, SHIFT and GAP.
REQ-015 IDLE -> SHIFT when i_En=1, starting at digit 0, segment 0 on the next edge.
REQ-016 In SHIFT, o_SegSel SHALL advance by 1 each cycle from 0 to 6.
REQ-017 After segment 6, the FSM SHALL go to GAP when GAP_CYCLES>0, otherwise directly to segment 0 of the next digit.
REQ-018 GAP SHALL last exactly GAP_CYCLES cycles, with o_SegSel=7 and o_SegData at its unlit value; it then goes to segment 0 of digit o_Disp+1 (mod 4).
REQ-019 Frame length SHALL be 4*(7+GAP_CYCLES) cycles, i.e. 32 cycles at the default.
REQ-020 o_Frame SHALL pulse in the first cycle of digit 0 segment 0 of every frame except the first frame after leaving IDLE.
REQ-021 Any cycle with i_En=0 SHALL return the FSM to IDLE on the next edge: o_Disp=0, o_SegSel=7, o_SegData unlit; shadow and pending state are retained.
REQ-022 i_Load=1 SHALL copy i_D0..i_D3 into a shadow register and set a pending flag; the latest load wins, and repeated loads before a boundary produce one o_Ack.
REQ-023 At a frame boundary (the edge entering digit 0 segment 0 from digit 3), a set pending flag SHALL copy shadow to active, clear pending and pulse o_Ack in that same cycle as o_Frame.
REQ-024 On entry from IDLE to SHIFT, a set pending flag SHALL also be applied as in REQ-023, but without an o_Frame pulse.
REQ-025 i_Load on a boundary edge SHALL apply the old pending data first, then hold the new data pending, leaving pending set; if nothing was pending, the new data waits for the next boundary.
REQ-026 o_SegData SHALL be bit o_SegSel of the 7-segment pattern of the active digit o_Disp (segment a=bit 0 ... g=bit 6), decoded combinationally from registered state only.
REQ-027 Active digit values 10..15 SHALL decode to all segments unlit.
REQ-028 With i_Blank_En=1, digit 3 SHALL be blanked if it is 0; digit 2 if digits 3 and 2 are 0; digit 1 if digits 3..1 are 0; digit 0 is never blanked.
REQ-029 Polarity SHALL follow SEG_ACTIVE_LOW, and all "unlit" values in this document follow that polarity.

Reset
REQ-030 i_RST=0 SHALL immediately force: state IDLE; o_Disp=0; o_SegSel=7; o_SegData unlit; o_Frame=0; o_Ack=0; active and shadow digits 0; pending 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame without generating an o_Frame or o_Ack pulse.
REQ-032 Release of reset SHALL take effect synchronously to clk_500u; the first SHIFT cycle occurs no earlier than the second edge after release.

Structure
REQ-033 State encoding, the segment count (7) and the digit count (4) SHALL live in a shared package, freq_meter_pkg.
REQ-034 BCD-to-segment decoding SHALL be a combinational sub-module, seg7_decode, with a 4-bit input and 7-bit output, instantiated once on the active digit selected by o_Disp.

Verification
REQ-035 Reset, enable, load 1234, blanking off -> o_Disp/o_SegSel walk 0/0..0/6, 0/7 for one cycle, 1/0 ...; frame period 32 cycles; o_SegData for digit 0 matches the segment pattern of 4.
REQ-036 Load 0007 with i_Blank_En=1 -> digits 3..1 all segments unlit; digit 0 shows 7; with i_Blank_En=0, digits 3..1 show 0.
REQ-037 i_Load 5555 mid-frame, then i_Load 6666 two cycles later -> displayed data unchanged until the boundary; a single o_Ack with o_Frame; active digits = 6666.
REQ-038 i_Load coincident with the boundary edge while 1111 is pending -> 1111 applied with o_Ack; new data applied one frame (32 cycles) later with a second o_Ack.
REQ-039 i_En dropped at digit 2 segment 3, re-raised 5 cycles later -> IDLE outputs, then restart at 0/0 with no o_Frame; pending data applied at restart with o_Ack.
REQ-040 i_RST pulsed low at digit 3 segment 5 with data pending -> all outputs at reset values immediately; no o_Ack; blank digits display as 0 after re-enable.
